// File: rtl/i2c_cfg_arbiter.sv
// i2c_cfg_arbiter: round-robin front end that lets two configuration
// requesters share one I2C write controller. A winning request's word is
// latched once, then launched (and re-launched on NACK/timeout) until it
// succeeds or the retry budget runs out, and the result goes back to that
// requester only.
module i2c_cfg_arbiter #(
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 65535
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        req0_valid,
  input  logic [23:0] req0_data,
  output logic        req0_grant,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [23:0] req1_data,
  output logic        req1_grant,
  output logic        req1_done,
  output logic        req1_err,
  output logic [23:0] i2c_data,
  output logic        i2c_go,
  input  logic        i2c_end,
  input  logic        i2c_ack,
  output logic        busy,
  output logic        owner
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int ATT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [ATT_W-1:0] MAX_RETRY_C = ATT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_END,
    RELEASE,
    REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [23:0]      data_q, data_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic             busy_q, busy_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic             win;
  logic [CNT_W-1:0] cnt_inc;

  // Next-state logic: arbitration, launch/retry sequencing and the result pulse.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = 2'b00;
    done_d  = 2'b00;
    err_d   = 2'b00;
    busy_d  = busy_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    win     = 1'b0;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          win          = (req0_valid && req1_valid) ? prio_q : req1_valid;
          data_d       = win ? req1_data : req0_data;
          grant_d[win] = 1'b1;
          owner_d      = win;
          busy_d       = 1'b1;
          prio_d       = ~win;
          att_d        = '0;
          fail_d       = 1'b0;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        fail_d  = 1'b0;
        state_d = WAIT_END;
      end
      WAIT_END: begin
        cnt_d = cnt_inc;
        if (i2c_end) begin
          fail_d  = i2c_ack;
          state_d = RELEASE;
        end else if (cnt_inc >= TIMEOUT_C) begin
          fail_d  = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!i2c_end) begin
          if (!fail_q) begin
            state_d = REPORT;
          end else if (att_q < MAX_RETRY_C) begin
            att_d   = att_q + ATT_W'(1);
            state_d = LAUNCH;
          end else begin
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        done_d[owner_q] = 1'b1;
        err_d[owner_q]  = fail_q;
        busy_d          = 1'b0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer without a result.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      data_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      att_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      att_q   <= att_d;
    end
  end

  assign i2c_go     = (state_q == LAUNCH) || (state_q == WAIT_END);
  assign i2c_data   = data_q;
  assign req0_grant = grant_q[0];
  assign req1_grant = grant_q[1];
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign busy       = busy_q;
  assign owner      = owner_q;

endmodule
